// File: rtl/chan_fifo_pkg.sv
// Definitions shared by the RX channel FIFO writer and the TX FIFO reader:
// header bit positions, the payload length limit, writer states and the header builder.
package chan_fifo_pkg;

    localparam int HDR_PAYLOAD_LSB = 2;
    localparam int HDR_PAYLOAD_W   = 7;
    localparam int HDR_RSSI_LSB    = 12;
    localparam int HDR_RSSI_W      = 8;
    localparam int HDR_CHAN_LSB    = 20;
    localparam int HDR_CHAN_W      = 5;
    localparam int HDR_OVERRUN_BIT = 26;
    localparam int HDR_EOB_BIT     = 27;
    localparam int HDR_SOB_BIT     = 28;

    localparam int MAX_PKT_LEN = 126;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HEADER,
        ST_TIMESTAMP,
        ST_FIRST,
        ST_PAYLOAD,
        ST_PAD,
        ST_EOB_HDR,
        ST_EOB_TS
    } wr_state_t;

    function automatic logic [31:0] build_header(
        input logic [HDR_PAYLOAD_W-1:0] len,
        input logic [HDR_RSSI_W-1:0]    rssi,
        input logic [HDR_CHAN_W-1:0]    chan,
        input logic                     ovr,
        input logic                     eob,
        input logic                     sob
    );
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_PAYLOAD_LSB +: HDR_PAYLOAD_W] = len;
        hdr[HDR_RSSI_LSB +: HDR_RSSI_W]       = rssi;
        hdr[HDR_CHAN_LSB +: HDR_CHAN_W]       = chan;
        hdr[HDR_OVERRUN_BIT]                  = ovr;
        hdr[HDR_EOB_BIT]                      = eob;
        hdr[HDR_SOB_BIT]                      = sob;
        return hdr;
    endfunction

endpackage

// File: rtl/chan_fifo_writer.sv
// Packs RX I/Q samples into header/timestamp/payload packets for one channel FIFO.
// Optional CHAN_RSSI_HDR_EN: carry the RSSI captured at packet start in header [19:12].
module chan_fifo_writer
    import chan_fifo_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int MAX_LEN = MAX_PKT_LEN
) (
    input  logic        rx_clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rx_strobe,
    input  logic [15:0] rx_i,
    input  logic [15:0] rx_q,
    input  logic [31:0] adc_time,
    input  logic [31:0] rssi,
    input  logic [6:0]  pkt_len,
    input  logic        space_ok,
    output logic [31:0] wrdata,
    output logic        wrreq,
    output logic        pkt_done,
    output logic        overrun,
    output logic [15:0] dropped_count,
    output logic        busy
);

    localparam logic [4:0] CHAN_ID   = 5'(CHANNEL);
    localparam logic [6:0] LEN_CLAMP = 7'(MAX_LEN);

    wr_state_t   state;
    logic [6:0]  len_q;
    logic [6:0]  count;
    logic [31:0] sample_q;
    logic [31:0] time_q;
    logic        sob_pend;
    logic        ovr_pend;

    logic [6:0]  len_sel;
    logic        start;
    logic        drop;
    logic [7:0]  rssi_live;
    logic [7:0]  rssi_held;
    logic [31:0] eob_hdr;

`ifdef CHAN_RSSI_HDR_EN
    logic [7:0] rssi_q;
    logic       unused_rssi;
    assign unused_rssi = ^rssi[31:8];
    assign rssi_live   = rssi[7:0];
    assign rssi_held   = rssi_q;

    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n)
            rssi_q <= '0;
        else if (start)
            rssi_q <= rssi[7:0];
    end
`else
    logic unused_rssi;
    assign unused_rssi = ^rssi;
    assign rssi_live   = '0;
    assign rssi_held   = '0;
`endif

    assign busy    = (state != ST_IDLE);
    assign eob_hdr = build_header(7'd0, rssi_held, CHAN_ID, ovr_pend, 1'b1, 1'b0);

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        len_sel = (pkt_len > LEN_CLAMP) ? LEN_CLAMP : pkt_len;
        start   = 1'b0;
        drop    = 1'b0;
        if (rx_strobe) begin
            case (state)
                ST_ARMED: begin
                    start = enable && (pkt_len != 7'd0) && space_ok;
                    drop  = enable && (pkt_len != 7'd0) && !space_ok;
                end
                ST_HEADER, ST_TIMESTAMP, ST_EOB_HDR, ST_EOB_TS: drop = 1'b1;
                default: ;
            endcase
        end
    end

    // The state names the word on wrdata this cycle; each word is loaded on the edge entering it.
    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            len_q         <= '0;
            count         <= '0;
            sample_q      <= '0;
            time_q        <= '0;
            sob_pend      <= 1'b0;
            ovr_pend      <= 1'b0;
            wrdata        <= '0;
            wrreq         <= 1'b0;
            pkt_done      <= 1'b0;
            overrun       <= 1'b0;
            dropped_count <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads pre-edge values.
            wrreq    <= 1'b0;
            pkt_done <= 1'b0;
            overrun  <= drop;

            case (state)
                ST_IDLE: begin
                    if (enable && pkt_len != 7'd0) begin
                        state    <= ST_ARMED;
                        sob_pend <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!enable) begin
                        sob_pend <= 1'b0;
                        if (sob_pend) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_EOB_HDR;
                            wrreq    <= 1'b1;
                            wrdata   <= eob_hdr;
                            ovr_pend <= 1'b0;
                        end
                    end else if (start) begin
                        state    <= ST_HEADER;
                        len_q    <= len_sel;
                        sample_q <= {rx_q, rx_i};
                        time_q   <= adc_time;
                        wrreq    <= 1'b1;
                        wrdata   <= build_header(len_sel, rssi_live, CHAN_ID, ovr_pend, 1'b0, sob_pend);
                        sob_pend <= 1'b0;
                        ovr_pend <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    state  <= ST_TIMESTAMP;
                    wrreq  <= 1'b1;
                    wrdata <= time_q;
                end
                ST_TIMESTAMP: begin
                    state  <= ST_FIRST;
                    wrreq  <= 1'b1;
                    wrdata <= sample_q;
                    count  <= 7'd1;
                end
                ST_FIRST, ST_PAYLOAD: begin
                    if (count == len_q) begin
                        pkt_done <= 1'b1;
                        if (enable) begin
                            state <= ST_ARMED;
                        end else begin
                            state    <= ST_EOB_HDR;
                            wrreq    <= 1'b1;
                            wrdata   <= eob_hdr;
                            ovr_pend <= 1'b0;
                        end
                    end else if (state == ST_FIRST) begin
                        state <= ST_PAYLOAD;
                    end else if (!enable) begin
                        state  <= ST_PAD;
                        wrreq  <= 1'b1;
                        wrdata <= '0;
                        count  <= count + 7'd1;
                    end else if (rx_strobe) begin
                        wrreq  <= 1'b1;
                        wrdata <= {rx_q, rx_i};
                        count  <= count + 7'd1;
                    end
                end
                ST_PAD: begin
                    if (count == len_q) begin
                        pkt_done <= 1'b1;
                        state    <= ST_EOB_HDR;
                        wrreq    <= 1'b1;
                        wrdata   <= eob_hdr;
                        ovr_pend <= 1'b0;
                    end else begin
                        wrreq  <= 1'b1;
                        wrdata <= '0;
                        count  <= count + 7'd1;
                    end
                end
                ST_EOB_HDR: begin
                    state  <= ST_EOB_TS;
                    wrreq  <= 1'b1;
                    wrdata <= adc_time;
                end
                ST_EOB_TS: begin
                    state    <= ST_IDLE;
                    pkt_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            if (drop) begin
                ovr_pend <= 1'b1;
                if (dropped_count != 16'hFFFF)
                    dropped_count <= dropped_count + 16'd1;
            end
        end
    end

endmodule
